// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec. The requester drives the operation and operands.
// The ALU returns the busy, done, result and zero-flag signals.
interface alu_exec_if #(parameter int WIDTH = 64);
  logic             Start;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] BusW;
  logic             Zero;

  modport master (output Start, ALUCtrl, BusA, BusB,
                  input  Busy, Done, BusW, Zero);
  modport slave  (input  Start, ALUCtrl, BusA, BusB,
                  output Busy, Done, BusW, Zero);
endinterface

// File: rtl/alu_exec.sv
// Single-issue ALU: AND/OR/ADD/SUB/pass-B with one-edge latency and registered result/zero flag.
// Define ALU_EXEC_MUL_EN to add code 1000, an unsigned WIDTH-cycle shift-add multiply.
module alu_exec #(
  parameter int WIDTH = 64
) (
  input  logic      Clk,
  input  logic      Reset_L,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;

`ifdef ALU_EXEC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nx;
`else
  typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;

  assign bus.Busy = (state_q != IDLE);

  // Unknown codes return zero, which also makes Zero read as 1.
  always_comb begin
    res = '0;
    case (op_q)
      OP_AND:  res = a_q & b_q;
      OP_ORR:  res = a_q | b_q;
      OP_ADD:  res = a_q + b_q;
      OP_SUB:  res = a_q - b_q;
      OP_PASS: res = b_q;
      default: res = '0;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  // One partial product per cycle. A shifts left and B shifts right.
  assign acc_nx = acc_q + (b_q[0] ? a_q : '0);
`endif

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bus.Done <= 1'b0;
      bus.BusW <= '0;
      bus.Zero <= 1'b1;
`ifdef ALU_EXEC_MUL_EN
      cnt_q    <= '0;
      acc_q    <= '0;
`endif
    end else begin
      bus.Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            op_q <= bus.ALUCtrl;
            a_q  <= bus.BusA;
            b_q  <= bus.BusB;
`ifdef ALU_EXEC_MUL_EN
            cnt_q <= '0;
            acc_q <= '0;
            if (bus.ALUCtrl == OP_MUL) state_q <= MUL;
            else                       state_q <= EXEC;
`else
            state_q <= EXEC;
`endif
          end
        end
        EXEC: begin
          bus.BusW <= res;
          bus.Zero <= (res == '0);
          bus.Done <= 1'b1;
          state_q  <= IDLE;
        end
`ifdef ALU_EXEC_MUL_EN
        MUL: begin
          acc_q <= acc_nx;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          // The WIDTH-th step retires the product, so Done lands at edge accept+WIDTH.
          if (cnt_q == LAST) begin
            bus.BusW <= acc_nx;
            bus.Zero <= (acc_nx == '0);
            bus.Done <= 1'b1;
            state_q  <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed, table-driven bench for alu_exec plus hand sequences for reset, back-to-back and code 1000.
module tb_alu_exec;
  localparam int WIDTH = 64;
  typedef logic [WIDTH-1:0] word_t;

  logic Clk = 1'b0;
  logic Reset_L;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();
  alu_exec #(.WIDTH(WIDTH)) dut (.Clk(Clk), .Reset_L(Reset_L), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    word_t      a;
    word_t      b;
    word_t      exp_w;
    logic       exp_z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Accept at the next edge, then sample one edge later, where Done should be high.
  task automatic run_op(input logic [3:0] op, input word_t a, input word_t b);
    bus.Start = 1'b1; bus.ALUCtrl = op; bus.BusA = a; bus.BusB = b;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, word_t'(bus.Busy), '0);
    check({tag, " done"}, word_t'(bus.Done), '0);
    check({tag, " busw"}, bus.BusW, '0);
    check({tag, " zero"}, word_t'(bus.Zero), word_t'(1));
  endtask

  initial begin
    int cyc;
    bit busy_ok, done_seen;

    vecs.push_back('{"add wrap",   4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1});
    vecs.push_back('{"sub neg",    4'b0110, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    vecs.push_back('{"and",        4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0});
    vecs.push_back('{"orr",        4'b0001, 64'hF0, 64'h3C, 64'hFC, 1'b0});
    vecs.push_back('{"pass b0",    4'b0111, 64'h1234, 64'h0, 64'h0, 1'b1});
    vecs.push_back('{"pass b",     4'b0111, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0});
    vecs.push_back('{"add",        4'b0010, 64'h2, 64'h3, 64'h5, 1'b0});
    vecs.push_back('{"sub zero",   4'b0110, 64'h99, 64'h99, 64'h0, 1'b1});
    vecs.push_back('{"bad 1111",   4'b1111, 64'hFF, 64'hFF, 64'h0, 1'b1});
    vecs.push_back('{"bad 0011",   4'b0011, 64'h1, 64'h1, 64'h0, 1'b1});

    Reset_L = 1'b0;
    bus.Start = 1'b0; bus.ALUCtrl = '0; bus.BusA = '0; bus.BusB = '0;
    #12;
    check_reset_vals("reset");

    // Release just before an edge; that very edge must accept.
    bus.Start = 1'b1; bus.ALUCtrl = 4'b0010; bus.BusA = 64'h2; bus.BusB = 64'h3;
    #1 Reset_L = 1'b1;
    @(posedge Clk); #1;
    check("first accept busy", word_t'(bus.Busy), word_t'(1));
    // Operand/op changes after accept must not leak into the result.
    bus.Start = 1'b0; bus.ALUCtrl = 4'b0000; bus.BusA = 64'h100;
    @(posedge Clk); #1;
    check("first done", word_t'(bus.Done), word_t'(1));
    check("first busw", bus.BusW, 64'h5);
    @(posedge Clk); #1;
    check("done one pulse", word_t'(bus.Done), '0);
    check("busw hold", bus.BusW, 64'h5);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, " done"}, word_t'(bus.Done), word_t'(1));
      check({vecs[i].name, " busw"}, bus.BusW, vecs[i].exp_w);
      check({vecs[i].name, " zero"}, word_t'(bus.Zero), word_t'(vecs[i].exp_z));
    end

    // Back-to-back: AND, then ORR presented while busy and held through Done.
    bus.Start = 1'b1; bus.ALUCtrl = 4'b0000; bus.BusA = 64'hF0; bus.BusB = 64'h3C;
    @(posedge Clk); #1;
    bus.ALUCtrl = 4'b0001;
    @(posedge Clk); #1;
    check("b2b and done", word_t'(bus.Done), word_t'(1));
    check("b2b and busw", bus.BusW, 64'h30);
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    check("b2b orr busy", word_t'(bus.Busy), word_t'(1));
    check("b2b orr no done", word_t'(bus.Done), '0);
    @(posedge Clk); #1;
    check("b2b orr done", word_t'(bus.Done), word_t'(1));
    check("b2b orr busw", bus.BusW, 64'hFC);

    // Reset during EXEC aborts the operation.
    bus.Start = 1'b1; bus.ALUCtrl = 4'b0010; bus.BusA = 64'h7; bus.BusB = 64'h1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    #2 Reset_L = 1'b0;
    #1;
    check_reset_vals("exec rst");
    #2 Reset_L = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      if (bus.Done) done_seen = 1;
    end
    check("exec rst no done", word_t'(done_seen), '0);

`ifdef ALU_EXEC_MUL_EN
    bus.Start = 1'b1; bus.ALUCtrl = 4'b1000; bus.BusA = 64'h3; bus.BusB = 64'h10;
    @(posedge Clk); #1;
    cyc = 0; busy_ok = 1;
    while (1) begin
      // Stray Start pulses while busy must be dropped.
      bus.Start = cyc[0]; bus.ALUCtrl = 4'b0010;
      @(posedge Clk); #1;
      cyc++;
      if (bus.Done) break;
      if (!bus.Busy) busy_ok = 0;
      if (cyc > WIDTH + 8) break;
    end
    bus.Start = 1'b0;
    check("mul latency", word_t'(cyc), word_t'(WIDTH));
    check("mul busy", word_t'(busy_ok), word_t'(1));
    check("mul busw", bus.BusW, 64'h30);
    check("mul zero", word_t'(bus.Zero), '0);
    @(posedge Clk); #1;
    check("mul done pulse", word_t'(bus.Done), '0);

    bus.Start = 1'b1; bus.ALUCtrl = 4'b1000; bus.BusA = 64'h3; bus.BusB = 64'h10;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset_L = 1'b0;
    #1;
    check_reset_vals("mul rst");
    #2 Reset_L = 1'b1;
    done_seen = 0;
    for (int k = 0; k < WIDTH + 8; k++) begin
      @(posedge Clk); #1;
      if (bus.Done) done_seen = 1;
    end
    check("mul rst no done", word_t'(done_seen), '0);
`else
    cyc = 0; busy_ok = 1;
    run_op(4'b1000, 64'h3, 64'h10);
    check("1000 done", word_t'(bus.Done), word_t'(1));
    check("1000 busw", bus.BusW, '0);
    check("1000 zero", word_t'(bus.Zero), word_t'(1));
`endif

    run_op(4'b0010, 64'h40, 64'h2);
    check("post done", word_t'(bus.Done), word_t'(1));
    check("post busw", bus.BusW, 64'h42);
    check("post zero", word_t'(bus.Zero), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
